// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer:
//   - data/address/op widths
//   - ALU op encodings
//   - sequencer FSM states
//   - instruction field bit positions
//   - helper that tells which ops update the carry flag
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int OP_W   = 3;
   localparam int NREGS  = 8;

   // Instruction word: [15:13] op, [12:10] rd, [9:7] rs_a, [6:4] rs_b,
   // [3] imm select, [2:0] reserved
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RSA_MSB = 9;
   localparam int RSA_LSB = 7;
   localparam int RSB_MSB = 6;
   localparam int RSB_LSB = 4;
   localparam int IMM_BIT = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_SHL = 3'b010,
      OP_ROR = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOT = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   // Only the arithmetic ops produce a meaningful carry/borrow.
   function automatic logic op_sets_carry(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file_8x16
// 8 x 16-bit register file: one synchronous write port, two combinational
// operand read ports and one combinational debug read port. Synchronous
// active-low clear of every entry.
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low clear
//   i_we         write enable
//   i_waddr      write address
//   i_wdata      write data
//   i_raddr_a/b  operand read addresses   -> o_rdata_a/b
//   i_raddr_d    debug read address       -> o_rdata_d
// -----------------------------------------------------------------------------
module reg_file_8x16
   import alu_seq_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   input  logic [ADDR_W-1:0] i_raddr_d,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b,
   output logic [DATA_W-1:0] o_rdata_d
);

   logic [DATA_W-1:0] r_mem [NREGS];

   // NOTE: clearing the array on reset turns it into flops rather than a RAM
   // macro; that is intended here because every entry must read 0 after reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Reads see the pre-write value during the write cycle.
   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];
   assign o_rdata_d = r_mem[i_raddr_d];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Operand/control shell around an external 16-bit combinational ALU. Accepts
// one instruction per three cycles (IDLE -> EXEC -> WB), reads operands from an
// 8x16 register file, drives the ALU, captures result/flags and writes back.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   instr_valid/instr     instruction handshake input
//   instr_ready           high in IDLE
//   alu_a/alu_b/alu_op    registered ALU inputs, stable through EXEC/WB
//   alu_result/z/c        ALU outputs, captured in EXEC
//   done/wb_data          writeback pulse and written value
//   flag_z/flag_c         registered flags, committed at writeback
//   dbg_addr/dbg_data     combinational debug read of the register file
// Build option:
//   ALU_SEQ_IMM_EN        instr[3]=1 replaces operand B with {13'b0, instr[6:4]}
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_z,
   input  logic              alu_c,
   output logic              done,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_z,
   output logic              flag_c,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            r_state, w_state_nxt;
   logic              w_accept, w_wr_en;
   logic [DATA_W-1:0] w_rd_a, w_rd_b, w_b_sel;

   logic [DATA_W-1:0] r_alu_a, r_alu_b, r_res;
   op_e               r_alu_op;
   logic [ADDR_W-1:0] r_rd;
   logic              r_z, r_c, r_c_en, r_flag_z, r_flag_c;

   reg_file_8x16 u_rf (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_we      (w_wr_en),
      .i_waddr   (r_rd),
      .i_wdata   (r_res),
      .i_raddr_a (instr[RSA_MSB:RSA_LSB]),
      .i_raddr_b (instr[RSB_MSB:RSB_LSB]),
      .i_raddr_d (dbg_addr),
      .o_rdata_a (w_rd_a),
      .o_rdata_b (w_rd_b),
      .o_rdata_d (dbg_data)
   );

`ifdef ALU_SEQ_IMM_EN
   logic w_unused_instr;
   assign w_unused_instr = ^instr[2:0];
   assign w_b_sel = instr[IMM_BIT] ? {13'b0, instr[RSB_MSB:RSB_LSB]} : w_rd_b;
`else
   logic w_unused_instr;
   assign w_unused_instr = ^instr[IMM_BIT:0];
   assign w_b_sel = w_rd_b;
`endif

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      instr_ready = 1'b0;
      w_accept    = 1'b0;
      w_wr_en     = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_WB;
         S_WB: begin
            done        = 1'b1;
            w_wr_en     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= OP_ADD;
         r_rd     <= '0;
         r_res    <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_c_en   <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_a  <= w_rd_a;
            r_alu_b  <= w_b_sel;
            r_alu_op <= op_e'(instr[OP_MSB:OP_LSB]);
            r_rd     <= instr[RD_MSB:RD_LSB];
         end
         if (r_state == S_EXEC) begin
            r_res  <= alu_result;
            r_z    <= alu_z;
            r_c    <= alu_c;
            r_c_en <= op_sets_carry(r_alu_op);
         end
         // Flags commit together with the register write.
         if (w_wr_en) begin
            r_flag_z <= r_z;
            if (r_c_en) r_flag_c <= r_c;
         end
      end
   end

   assign alu_a   = r_alu_a;
   assign alu_b   = r_alu_b;
   assign alu_op  = r_alu_op;
   assign wb_data = r_res;
   assign flag_z  = r_flag_z;
   assign flag_c  = r_flag_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. Supplies a behavioural ALU, keeps a
// register-file/flag reference model, runs directed steps followed by random
// instructions. Honours ALU_SEQ_IMM_EN for the immediate operand.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_z, alu_c;
   logic        done;
   logic [15:0] wb_data;
   logic        flag_z, flag_c;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [15:0] m_reg [8];
   logic        m_z, m_c;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_z       (alu_z),
      .alu_c       (alu_c),
      .done        (done),
      .wb_data     (wb_data),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // Returns {carry, result}. Logical ops report result[0] as carry so that
   // any wrongful carry update is visible.
   function automatic logic [16:0] alu_fn(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      logic [15:0] r;
      logic        c;
      r = '0;
      c = 1'b0;
      case (op)
         3'd0: {c, r} = {1'b0, a} + {1'b0, b};
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: begin r = a << 1; c = a[15]; end
         3'd3: begin r = {a[0], a[15:1]}; c = a[0]; end
         3'd4: begin r = a & b; c = r[0]; end
         3'd5: begin r = a | b; c = r[0]; end
         3'd6: begin r = a ^ b; c = r[0]; end
         default: begin r = ~a; c = r[0]; end
      endcase
      return {c, r};
   endfunction

   always_comb begin
      {alu_c, alu_result} = alu_fn(alu_op, alu_a, alu_b);
      alu_z = (alu_result == 16'h0000);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_z = 1'b0;
      m_c = 1'b0;
   endtask

   // Called at a negedge. Issues one instruction, follows it through EXEC and
   // WB, returns at the negedge after writeback. With hold set, instr_valid
   // stays high and instr switches to nxt while the sequencer is busy.
   task automatic exec_instr(input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] ra, input logic [2:0] rb,
                             input logic imm, input bit hold,
                             input logic [15:0] nxt);
      logic [15:0] a, b, r;
      logic [16:0] cr;
      logic        c;
      int          wait_n;
      instr       = {op, rd, ra, rb, imm, 3'($urandom)};
      instr_valid = 1'b1;
      wait_n      = 0;
      while (instr_ready !== 1'b1 && wait_n < 8) begin
         @(negedge clk);
         wait_n++;
      end
      if (instr_ready !== 1'b1) begin
         check("accept_timeout", 16'(instr_ready), 16'd1);
         instr_valid = 1'b0;
         return;
      end
      a = m_reg[ra];
      b = m_reg[rb];
`ifdef ALU_SEQ_IMM_EN
      if (imm) b = {13'b0, rb};
`endif
      cr = alu_fn(op, a, b);
      c  = cr[16];
      r  = cr[15:0];

      @(negedge clk);                       // EXEC
      if (hold) instr = nxt;
      else      instr_valid = 1'b0;
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      check("exec_alu_op", 16'(alu_op), 16'(op));
      check("exec_ready", 16'(instr_ready), 16'd0);
      check("exec_done", 16'(done), 16'd0);

      @(negedge clk);                       // WB
      check("wb_done", 16'(done), 16'd1);
      check("wb_data", wb_data, r);
      check("wb_ready", 16'(instr_ready), 16'd0);
      dbg_addr = rd;
      #1;
      check("wb_dbg_prewrite", dbg_data, m_reg[rd]);
      m_reg[rd] = r;
      m_z       = (r == 16'h0000);
      if (op == 3'd0 || op == 3'd1) m_c = c;

      @(negedge clk);                       // back in IDLE
      check("post_done", 16'(done), 16'd0);
      check("post_ready", 16'(instr_ready), 16'd1);
      check("post_flag_z", 16'(flag_z), 16'(m_z));
      check("post_flag_c", 16'(flag_c), 16'(m_c));
      check("post_dbg_rd", dbg_data, m_reg[rd]);
   endtask

   task automatic check_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
      dbg_addr = addr;
      #1;
      check(tag, dbg_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_valid = 1'b0;
      instr       = 16'h0000;
      dbg_addr    = 3'd0;
      reset       = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      // Reset state
      for (int i = 0; i < 8; i++) check_reg("rst_dbg", 3'(i), 16'h0000);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", 16'(instr_ready), 16'd1);
      check("rst_flag_z", 16'(flag_z), 16'd0);
      check("rst_flag_c", 16'(flag_c), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_wb_data", wb_data, 16'h0000);
      check("rst_alu_a", alu_a, 16'h0000);
      check("rst_alu_b", alu_b, 16'h0000);
      check("rst_alu_op", 16'(alu_op), 16'd0);

      // Preload R1=0xFFFF (NOT R0), R2=0x0001 (R0-R1 wraps)
      exec_instr(3'd7, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      exec_instr(3'd1, 3'd2, 3'd0, 3'd1, 1'b0, 1'b0, 16'h0);
      check_reg("pre_r1", 3'd1, 16'hFFFF);
      check_reg("pre_r2", 3'd2, 16'h0001);

      // ADD carry: R3 = R1 + R2
      exec_instr(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 16'h0);
      check_reg("add_r3", 3'd3, 16'h0000);
      check("add_flag_z", 16'(flag_z), 16'd1);
      check("add_flag_c", 16'(flag_c), 16'd1);

      // Flag hold: XOR R4 = R3 ^ R3 leaves carry alone
      exec_instr(3'd6, 3'd4, 3'd3, 3'd3, 1'b0, 1'b0, 16'h0);
      check_reg("xor_r4", 3'd4, 16'h0000);
      check("xor_flag_z", 16'(flag_z), 16'd1);
      check("xor_flag_c", 16'(flag_c), 16'd1);

      // SUB R5 = R1 - R2 = 0xFFFE, no borrow
      exec_instr(3'd1, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 16'h0);
      check_reg("sub_r5", 3'd5, 16'hFFFE);
      check("sub_flag_z", 16'(flag_z), 16'd0);
      check("sub_flag_c", 16'(flag_c), 16'd0);

      // Back-to-back dependency: ADD R1=R1+R2 then SHL R1, valid held high
      exec_instr(3'd0, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1, {3'd2, 3'd1, 3'd1, 3'd0, 4'b0000});
      exec_instr(3'd2, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 16'h0);
      check_reg("b2b_r1", 3'd1, 16'h0000);

      // Build R2 = 0x0010 by four shifts, then the immediate case
      for (int i = 0; i < 4; i++) exec_instr(3'd2, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0);
      check_reg("shl_r2", 3'd2, 16'h0010);
      exec_instr(3'd0, 3'd2, 3'd2, 3'd5, 1'b1, 1'b0, 16'h0);
`ifdef ALU_SEQ_IMM_EN
      check_reg("imm_r2", 3'd2, 16'h0015);
`else
      check_reg("imm_r2", 3'd2, 16'h000E);
`endif

      // Reset during EXEC of a write to R6
      instr       = {3'd7, 3'd6, 3'd0, 3'd0, 4'b0000};
      instr_valid = 1'b1;
      @(negedge clk);
      check("abort_exec_ready", 16'(instr_ready), 16'd0);
      instr_valid = 1'b0;
      reset       = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("abort_done", 16'(done), 16'd0);
      end
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("abort_done_rel", 16'(done), 16'd0);
      check("abort_ready", 16'(instr_ready), 16'd1);
      check("abort_flag_c", 16'(flag_c), 16'd0);
      check_reg("abort_r6", 3'd6, 16'h0000);

      // Seed a nonzero register, then random instructions
      exec_instr(3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 40; i++) begin
         exec_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'b0, 16'h0);
      end
      for (int i = 0; i < 8; i++) check_reg("final_reg", 3'(i), m_reg[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand and control sequencer that drives the 16-bit combinational ALU from the other side of its interface. It accepts encoded instructions over a valid/ready handshake, reads two operands from an internal 8×16 register file, and presents A/B/op to the ALU. It then captures result, Z and C and writes the result back. It forms the control/datapath shell around the ALU in the Project 4 processor.

## Interface
Parameters: none (widths fixed: 16-bit data, 3-bit op, 3-bit register address).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr  in  16  [15:13] op, [12:10] rd, [9:7] rs_a, [6:4] rs_b, [3] imm (IMM_EN only), [2:0] reserved
- instr_ready  out  1  sequencer can accept an instruction
- alu_a  out  16  operand A to ALU
- alu_b  out  16  operand B to ALU
- alu_op  out  3  op code to ALU
- alu_result  in  16  ALU result
- alu_z  in  1  ALU zero flag
- alu_c  in  1  ALU carry/borrow flag
- done  out  1  one-cycle pulse on writeback
- wb_data  out  16  value written on the done cycle
- flag_z  out  1  registered zero flag
- flag_c  out  1  registered carry flag
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of register dbg_addr

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch op/rd/operands.
  - alu_a<=R[rs_a], alu_b<=R[rs_b], alu_op<=op.
  - Go to EXEC.
- EXEC: instr_ready=0, ALU inputs held stable. Capture alu_result and alu_z into internal registers. Capture alu_c only for op 000 (ADD) and 001 (SUB); flag_c holds its old value for all other ops. Go to WB.
- WB: R[rd]<=captured result; wb_data=captured result; done=1; flag_z/flag_c update. Go to IDLE.
- rd may equal rs_a/rs_b. Operands are read in IDLE, so the old value is used.
- Consecutive dependent instructions are hazard-free, because each instruction is fully written back before the next is accepted.
- dbg_data=R[dbg_addr] combinationally. A read of the register being written in WB returns the pre-write value.
- All register file entries are writable, including R0. There is no hardwired zero.

## Timing
- Accept at edge N; alu_a/alu_b/alu_op valid after edge N.
- Result captured at edge N+1; writeback and done pulse during cycle after N+1, committed at edge N+2.
- instr_ready returns high after edge N+2. Throughput is 1 instruction per 3 cycles.
- instr_valid while instr_ready=0 is ignored; the source must hold valid and instr until accepted.
- Reset values (reset=0 at any edge):
  - state=IDLE, instr_ready=1 after release.
  - alu_a=alu_b=0, alu_op=000.
  - done=0, wb_data=0, flag_z=0, flag_c=0.
  - All 8 registers=0.
- Reset in EXEC or WB aborts the instruction: no register write, no done pulse.
- Arithmetic wraps modulo 2^16. The sequencer performs no widening; the carry comes solely from alu_c.

## Configuration
- ALU_SEQ_IMM_EN defined: instr[3]=1 selects alu_b={13'b0, instr[6:4]} (3-bit unsigned immediate) instead of R[rs_b]. instr[3]=0 behaves as normal.
- ALU_SEQ_IMM_EN undefined: instr[3] is ignored and alu_b is always R[rs_b].

## Structure
- Package alu_seq_pkg holds:
  - op encodings: ADD 000, SUB 001, SHL 010, ROR 011, AND 100, OR 101, XOR 110, NOT 111.
  - state enum (IDLE/EXEC/WB).
  - instruction field bit positions.
  - widths: DATA_W=16, ADDR_W=3.
- One sub-module, reg_file_8x16: synchronous single write port, two combinational operand read ports plus one debug read port, synchronous active-low clear.

## Test plan
- Reset, write-free read: assert reset → dbg_data=0 for all addresses, instr_ready=1, flag_z=0, flag_c=0.
- ADD carry: preload R1=0xFFFF, R2=0x0001 (via prior ops); ADD rd=3,rs_a=1,rs_b=2 → done pulse 2 cycles after accept, R3=0x0000, flag_z=1, flag_c=1.
- Flag hold: after the ADD above, XOR R4=R3^R3 → R4=0, flag_z=1, flag_c stays 1. A subsequent SUB 5−3 → flag_c per alu_c, flag_z=0.
- Back-to-back dependency: instr_valid held high with ADD R1=R1+R2 then SHL R1 → second instruction accepted only after done; R1 reflects the first result before the shift.
- Reset mid-op: assert reset during EXEC of a write to R6 → R6 remains 0, no done pulse, instr_ready=1 after release.
- IMM (ALU_SEQ_IMM_EN): ADD rd=2, rs_a=2 (R2=0x0010), imm=1, instr[6:4]=5 → R2=0x0015. Same stimulus without the macro → B=R5.
